// File: rtl/tff_dec_pkg.sv
// Shared types and default parameters for the TFF stream decoder.
package tff_dec_pkg;

  typedef enum logic {COLLECT, FULL} tff_dec_state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/tff_dec_outreg.sv
// Single-entry valid/ready output register for recovered words.
// Optional parity bit is present when TFF_DEC_PARITY_EN is defined.
module tff_dec_outreg
  import tff_dec_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef TFF_DEC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  // A load always wins over a drain, so a same-cycle transfer and reload keeps valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef TFF_DEC_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_parity <= 1'b0;
    end else if (load) begin
      out_parity <= ^load_data;
    end
  end
`endif

endmodule

// File: rtl/tff_stream_decoder.sv
// Recovers the toggle input of a TFF from its sampled output and packs it LSB-first into words.
// Optional out_parity port enabled by TFF_DEC_PARITY_EN.
module tff_stream_decoder
  import tff_dec_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             q,
  input  logic             q_valid,
  output logic             q_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] toggle_cnt
`ifdef TFF_DEC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int unsigned BC_W = $clog2(WIDTH);

  tff_dec_state_t   state;
  tff_dec_state_t   state_nxt;
  logic             ref_q;
  logic [BC_W-1:0]  bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             take;
  logic             t_bit;
  logic             word_done;
  logic             slot_free;
  logic             load;
  logic [WIDTH-1:0] load_data;

  assign q_ready   = (state == COLLECT);
  assign accept    = q_valid & q_ready;
  assign take      = accept & ~clr;
  assign t_bit     = q ^ ref_q;
  assign word_done = take & (bit_cnt == BC_W'(WIDTH - 1));
  assign slot_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and output-register load; clr always returns to COLLECT and drops any held word.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_data = '0;
    case (state)
      COLLECT: begin
        if (word_done) begin
          if (slot_free) begin
            load      = 1'b1;
            load_data = {t_bit, shreg[WIDTH-2:0]};
          end else begin
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (clr) begin
          state_nxt = COLLECT;
        end else if (out_valid & out_ready) begin
          load      = 1'b1;
          load_data = shreg;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Sample history and word assembly; shreg keeps a completed word while stalled in FULL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clr) begin
      ref_q   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (take) begin
      ref_q          <= q;
      shreg[bit_cnt] <= t_bit;
      bit_cnt        <= word_done ? '0 : bit_cnt + BC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle_cnt <= '0;
    end else if (take & t_bit & ~(&toggle_cnt)) begin
      toggle_cnt <= toggle_cnt + CNT_W'(1);
    end
  end

  tff_dec_outreg #(
    .WIDTH(WIDTH)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef TFF_DEC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

endmodule
